match_ack_controller: RTL and testbench

MATCH_ACK_CONTROLLER -- requirements
Module: match_ack_controller

---
 rtl/match_ack_controller.sv | 103 ++++++++++
 tb/tb_match_ack_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_ack_controller.sv
// Acknowledge handshake for an upstream pattern detector: captures one match per
// found_pattern assertion, holds ack low for a programmable delay, and counts matches.
module match_ack_controller #(
    parameter int ACK_DELAY = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             found_pattern,
    input  logic             hold,
    input  logic             clear_count,
    output logic             ack,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        READY   = 2'd0,
        CAPTURE = 2'd1,
        DELAY   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]       TIMER_LOAD = 8'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic       capture;
    logic       count_inc;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            READY: begin
                if (found_pattern) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = DELAY;
                timer_nxt = TIMER_LOAD;
            end
            DELAY: begin
                // hold only matters once the timer has expired
                if (timer != 8'd0) begin
                    timer_nxt = timer - 8'd1;
                end else if (!hold) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!found_pattern) begin
                    state_nxt = READY;
                end
            end
            default: begin
                state_nxt = READY;
                timer_nxt = 8'd0;
            end
        endcase
    end

    assign capture   = (state == READY) && found_pattern;
    assign count_inc = capture && (match_count != CNT_MAX);

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state       <= READY;
            timer       <= 8'd0;
            ack         <= 1'b1;
            match_pulse <= 1'b0;
            busy        <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            ack         <= (state_nxt == READY) || (state_nxt == RELEASE);
            match_pulse <= (state_nxt == CAPTURE);
            busy        <= (state_nxt != READY);
            if (clear_count) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (count_inc) begin
                match_count <= match_count + CNT_W'(1);
                if (match_count == CNT_MAX - CNT_W'(1)) begin
                    count_sat <= 1'b1;
                end
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_match_ack_controller.sv
// Self-checking bench for match_ack_controller: directed scenarios plus random traffic,
// compared every cycle against a phase/counter model of the handshake.
module tb_match_ack_controller;

    localparam int ACK_DELAY = 4;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset_sync;
    logic             found_pattern;
    logic             hold;
    logic             clear_count;
    logic             ack;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
    logic             busy;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [CNT_W-1:0] exp_q[$];

    match_ack_controller #(.ACK_DELAY(ACK_DELAY), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_sync    (reset_sync),
        .found_pattern (found_pattern),
        .hold          (hold),
        .clear_count   (clear_count),
        .ack           (ack),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .count_sat     (count_sat),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    // low: ack-low cycles still to go in this handshake (hold freezes the last one);
    // rel: ack is back high but found_pattern has not yet been seen low.
    typedef struct packed {
        logic [8:0]       low;
        logic             rel;
        logic [CNT_W-1:0] count;
        logic             sat;
        logic             pulse;
    } model_t;

    model_t m = '0;

    function automatic logic is_cap(model_t s, logic f);
        return (s.low == 9'd0) && !s.rel && f;
    endfunction

    function automatic model_t step(model_t s, logic f, logic h, logic c);
        model_t n   = s;
        logic   cap = is_cap(s, f);
        n.pulse = cap;
        if (c) begin
            n.count = '0;
            n.sat   = 1'b0;
        end else if (cap && s.count != CMAX) begin
            n.count = s.count + 1'b1;
            if (n.count == CMAX) n.sat = 1'b1;
        end
        if (cap) begin
            n.low = 9'(ACK_DELAY + 1);
        end else if (s.low != 9'd0) begin
            if (!(s.low == 9'd1 && h)) begin
                n.low = s.low - 9'd1;
                n.rel = (s.low == 9'd1);
            end
        end else if (s.rel && !f) begin
            n.rel = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset_sync) begin
            m <= '0;
        end else begin
            if (is_cap(m, found_pattern)) exp_q.push_back(step(m, found_pattern, hold, clear_count).count);
            m <= step(m, found_pattern, hold, clear_count);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ack",         32'(ack),         32'(m.low == 9'd0));
            check("busy",        32'(busy),        32'((m.low != 9'd0) || m.rel));
            check("match_pulse", 32'(match_pulse), 32'(m.pulse));
            check("match_count", 32'(match_count), 32'(m.count));
            check("count_sat",   32'(count_sat),   32'(m.sat));
            if (match_pulse === 1'b1) begin
                if (exp_q.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
                else check("pulse_count", 32'(match_count), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_sync = 1'b1; found_pattern = 1'b0; hold = 1'b0; clear_count = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_sync = 1'b0;
    endtask

    // One full handshake; hold is kept high until hold_extra stall cycles have elapsed.
    task automatic do_match(input int hold_extra, output int low, output int pulses);
        bit rose = 0;
        @(negedge clk);
        found_pattern = 1'b1;
        hold = (hold_extra > 0);
        low = 0;
        pulses = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (ack) begin
                rose = 1;
                break;
            end
            low++;
            pulses += int'(match_pulse);
            if (hold_extra > 0 && low == ACK_DELAY + 1 + hold_extra) hold = 1'b0;
        end
        check("ack_rise_timeout", 32'(rose), 32'd1);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        found_pattern = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int low;
        int pulses;
        bit rose;
        reset_sync = 1'b1; found_pattern = 1'b0; hold = 1'b0; clear_count = 1'b0;
        @(negedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        reset_sync = 1'b0;
        check("rst_ack",   32'(ack),         32'd1);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_pulse", 32'(match_pulse), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_sat",   32'(count_sat),   32'd0);
        $display("reset state code %0d", fsm_state);

        // basic match around cycle 10
        repeat (7) @(negedge clk);
        do_match(0, low, pulses);
        check("basic_low",    32'(low),         32'd5);
        check("basic_pulses", 32'(pulses),      32'd1);
        check("basic_count",  32'(match_count), 32'd1);
        check("basic_ready",  32'(busy),        32'd0);

        // hold stall of 6 cycles at timer 0
        do_match(6, low, pulses);
        check("hold_low",   32'(low),         32'd11);
        check("hold_count", 32'(match_count), 32'd2);

        // stuck found_pattern
        @(negedge clk);
        found_pattern = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            pulses += int'(match_pulse);
        end
        check("stuck_pulses", 32'(pulses),      32'd1);
        check("stuck_ack",    32'(ack),         32'd1);
        check("stuck_busy",   32'(busy),        32'd1);
        check("stuck_count",  32'(match_count), 32'd3);
        found_pattern = 1'b0;
        @(negedge clk);
        check("stuck_ready", 32'(busy), 32'd0);

        // saturation
        do_reset(1);
        for (int i = 1; i <= 17; i++) begin
            do_match(0, low, pulses);
            if (i == 14) begin
                check("sat14_count", 32'(match_count), 32'd14);
                check("sat14_flag",  32'(count_sat),   32'd0);
            end
            if (i == 15 || i == 17) begin
                check("sat_count", 32'(match_count), 32'd15);
                check("sat_flag",  32'(count_sat),   32'd1);
            end
        end

        // clear colliding with capture
        @(negedge clk);
        found_pattern = 1'b1;
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        check("clr_pulse", 32'(match_pulse), 32'd1);
        check("clr_count", 32'(match_count), 32'd0);
        check("clr_sat",   32'(count_sat),   32'd0);
        rose = 0;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (ack) begin
                rose = 1;
                break;
            end
        end
        check("clr_ack_rise", 32'(rose), 32'd1);
        found_pattern = 1'b0;
        @(negedge clk);

        // reset in the second DELAY cycle
        @(negedge clk);
        found_pattern = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_count", 32'(match_count), 32'd1);
        reset_sync = 1'b1;
        found_pattern = 1'b0;
        @(negedge clk);
        reset_sync = 1'b0;
        check("mid_rst_ack",   32'(ack),         32'd1);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_count", 32'(match_count), 32'd0);
        do_match(0, low, pulses);
        check("post_rst_low",   32'(low),         32'd5);
        check("post_rst_count", 32'(match_count), 32'd1);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            found_pattern = ($urandom_range(0, 2) != 0);
            hold          = ($urandom_range(0, 2) == 0);
            clear_count   = ($urandom_range(0, 24) == 0);
            reset_sync    = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        found_pattern = 1'b0; hold = 1'b0; clear_count = 1'b0; reset_sync = 1'b0;
        repeat (20) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
